seq_mult_n: RTL and testbench

- Parametrised sequential signed multiplier datapath with control: {X, A, B} shift register, WIDTH+1-bit add/subtract unit, and a cycle-counting control FSM.
- Next-generation replacement for the fixed 8-bit multiplier processor.
- Computes the 2·WIDTH-bit two's-complement product S×B into {A,B}, one multiplier bit per two cycles.
- Sits behind the board-level synchronizers and feeds hex display drivers instantiated by the top level.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/seq_mult_n_if.sv | 28 ++
 rtl/mult_ctrl_n.sv | 91 +++++++++
 rtl/seq_mult_n.sv | 89 ++++++++
 tb/tb_seq_mult_n.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the seq_mult_n sequential signed multiplier.
//   state_t    : control FSM states (IDLE, ADD, SHIFT, HOLD)
//   cnt_width(): width of the bit counter that indexes multiplier bits
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // The counter must reach WIDTH-1. The result is never allowed to drop
  // below one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_n_if.sv
// -----------------------------------------------------------------------------
// seq_mult_n_if
// Operand/result bundle for seq_mult_n.
//   run, clra_ldb, s           : driven by the controlling side (master)
//   aval, bval, x, busy, done  : driven by the multiplier (slave)
// -----------------------------------------------------------------------------
interface seq_mult_n_if #(
  parameter int WIDTH = 8
);
  logic             run;
  logic             clra_ldb;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] aval;
  logic [WIDTH-1:0] bval;
  logic             x;
  logic             busy;
  logic             done;

  modport master (
    output run, clra_ldb, s,
    input  aval, bval, x, busy, done
  );

  modport slave (
    input  run, clra_ldb, s,
    output aval, bval, x, busy, done
  );
endinterface

// File: rtl/mult_ctrl_n.sv
// -----------------------------------------------------------------------------
// mult_ctrl_n
// Control FSM and bit counter for seq_mult_n. One multiplier bit takes two
// cycles: ADD (conditional add/subtract) followed by SHIFT.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   run, clra_ldb  : start level / clear-A-load-B request (acted on in IDLE)
//   start          : IDLE->ADD transition this cycle
//   clear_a        : zero A and X this cycle
//   load_b         : load B from s this cycle
//   add, sub       : ADD state; sub on the final (sign) bit, add on the others
//   shift          : SHIFT state
//   busy           : ADD or SHIFT
//   done           : final SHIFT, the cycle before HOLD
//
// Build option: define MULT_AUTOCLEAR_EN to also zero A/X when a run starts.
// Without it A is kept, which turns each run into a multiply-accumulate.
// -----------------------------------------------------------------------------
module mult_ctrl_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clra_ldb,
  output logic start,
  output logic clear_a,
  output logic load_b,
  output logic add,
  output logic sub,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          last_bit;

  assign last_bit = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its inputs from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (start) cnt <= '0;
    else if (shift) cnt <= cnt + CW'(1);
  end

  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = last_bit ? HOLD : ADD;
      HOLD:    if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // run wins over clra_ldb in IDLE.
  always_comb begin
    start   = (state == IDLE) && run;
    load_b  = (state == IDLE) && !run && clra_ldb;
`ifdef MULT_AUTOCLEAR_EN
    clear_a = (state == IDLE) && (run || clra_ldb);
`else
    clear_a = (state == IDLE) && !run && clra_ldb;
`endif
    add     = (state == ADD) && !last_bit;
    sub     = (state == ADD) &&  last_bit;
    shift   = (state == SHIFT);
    busy    = (state == ADD) || (state == SHIFT);
    done    = (state == SHIFT) && last_bit;
  end

endmodule

// File: rtl/seq_mult_n.sv
// -----------------------------------------------------------------------------
// seq_mult_n
// Sequential two's-complement multiplier. The {X, A, B} shift register holds
// the running product; a WIDTH+1-bit adder adds S for every set multiplier
// bit, except the sign bit, where S is subtracted. After 2*WIDTH busy cycles
// {A, B} holds the 2*WIDTH-bit product.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : run, clra_ldb, s in; aval (A), bval (B), x, busy, done out
//
// Build option: MULT_AUTOCLEAR_EN (decoded in mult_ctrl_n) clears A/X at
// start. Without it the result is S*B + sext(A_initial), mod 2^(2*WIDTH).
// -----------------------------------------------------------------------------
module seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_mult_n_if.slave  bus
);

  logic             start;
  logic             clear_a;
  logic             load_b;
  logic             add;
  logic             sub;
  logic             shift;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             x;
  logic [WIDTH:0]   s_opnd;
  logic [WIDTH:0]   sum;

  mult_ctrl_n #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .run      (bus.run),
    .clra_ldb (bus.clra_ldb),
    .start    (start),
    .clear_a  (clear_a),
    .load_b   (load_b),
    .add      (add),
    .sub      (sub),
    .shift    (shift),
    .busy     (busy),
    .done     (done)
  );

  // Subtraction is done as an invert-plus-one of sext(S). Both operands are
  // sign-extended to WIDTH+1 bits, so even -2^(W-1) - (-2^(W-1)) stays in
  // range.
  always_comb begin
    s_opnd = {bus.s[WIDTH-1], bus.s} ^ {(WIDTH+1){sub}};
    sum    = {a[WIDTH-1], a} + s_opnd + {{WIDTH{1'b0}}, sub};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      x <= 1'b0;
    end else if (clear_a) begin
      a <= '0;
      x <= 1'b0;
    end else if (start) begin
      x <= a[WIDTH-1];
    end else if ((add || sub) && b[0]) begin
      {x, a} <= sum;
    end else if (shift) begin
      a <= {x, a[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       b <= '0;
    else if (load_b) b <= bus.s;
    else if (shift)  b <= {a[0], b[WIDTH-1:1]};
  end

  assign bus.aval = a;
  assign bus.bval = b;
  assign bus.x    = x;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_seq_mult_n.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_n
// Bench for seq_mult_n. It drives a WIDTH=8 instance with directed and random
// operations. A transaction-level model predicts busy/done every cycle and
// predicts {aval, bval, x} whenever the unit is not busy. A WIDTH=16 instance
// gets one directed product.
// -----------------------------------------------------------------------------
module tb_seq_mult_n;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_mult_n_if #(.WIDTH(8))  if8 ();
  seq_mult_n_if #(.WIDTH(16)) if16 ();

  seq_mult_n #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  seq_mult_n #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (WIDTH=8) ----------------
  // Result of one run: S*B, plus sext(A) when A is not auto-cleared.
  // Bit 16 is the sign of the exact value, which is where X ends up.
  function automatic logic [16:0] model_result(input logic [7:0] sv,
                                               input logic [7:0] bv,
                                               input logic [7:0] av);
    longint full;
    full = longint'($signed(sv)) * longint'($signed(bv));
`ifndef MULT_AUTOCLEAR_EN
    full = full + longint'($signed(av));
`endif
    return full[16:0];
  endfunction

  logic [7:0]  m_a, m_b;
  logic        m_x;
  logic [16:0] m_res;
  int          m_cnt;   // busy cycles still to go
  bit          m_hold;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_x <= 1'b0; m_cnt <= 0; m_hold <= 1'b0;
      m_res <= '0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hold <= 1'b1;
        {m_x, m_a, m_b} <= m_res;
      end
    end else if (m_hold) begin
      if (!if8.run) m_hold <= 1'b0;
    end else if (if8.run) begin
      m_cnt <= 16;
      m_res <= model_result(if8.s, m_b, m_a);
    end else if (if8.clra_ldb) begin
      m_a <= '0; m_x <= 1'b0; m_b <= if8.s;
    end
  end

  // One compare process: status every cycle, registers whenever idle/holding.
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("busy8", if8.busy, (m_cnt > 0));
      check("done8", if8.done, (m_cnt == 1));
      if (m_cnt == 0) begin
        check("prod8", {if8.aval, if8.bval}, {m_a, m_b});
        check("x8", if8.x, m_x);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic load8(input logic [7:0] v);
    @(negedge clk);
    if8.clra_ldb = 1'b1;
    if8.s        = v;
    @(negedge clk);
    if8.clra_ldb = 1'b0;
  endtask

  // Starts a run and returns at the first negedge in HOLD (run still high).
  task automatic run8(input logic [7:0] v, output int done_at);
    @(negedge clk);
    if8.s   = v;
    if8.run = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (if8.done && done_at < 0) done_at = k;
      if (!if8.busy) break;
    end
    check("wait_hold8", if8.busy, 1'b0);
  endtask

  task automatic release8();
    @(negedge clk);
    if8.run = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_at;
    int busy_cnt;
    logic [7:0] sv;

    reset = 1'b1;
    if8.run = 1'b0;  if8.clra_ldb = 1'b0;  if8.s = '0;
    if16.run = 1'b0; if16.clra_ldb = 1'b0; if16.s = '0;

    #1;
    check("rst_prod8", {if8.aval, if8.bval}, 16'h0000);
    check("rst_x8", if8.x, 1'b0);
    check("rst_busy8", if8.busy, 1'b0);
    check("rst_done8", if8.done, 1'b0);

    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // 7 x 3. The result stays in HOLD while run is high.
    load8(8'h07);
    run8(8'h03, done_at);
    check("lat_7x3", done_at, 16);
    check("res_7x3", {if8.aval, if8.bval, if8.x}, {16'h0015, 1'b0});
    repeat (3) @(negedge clk);
    check("hold_busy", if8.busy, 1'b0);
    check("hold_res", {if8.aval, if8.bval}, 16'h0015);
    release8();

    // -2 x 5.
    load8(8'hFE);
    run8(8'h05, done_at);
    check("res_m2x5", {if8.aval, if8.bval, if8.x}, {16'hFFF6, 1'b1});
    release8();

    // Most-negative corners.
    load8(8'h80);
    run8(8'h80, done_at);
    check("res_80x80", {if8.aval, if8.bval, if8.x}, {16'h4000, 1'b0});
    release8();
    load8(8'h80);
    run8(8'h7F, done_at);
    check("res_80x7F", {if8.aval, if8.bval, if8.x}, {16'hC080, 1'b1});
    release8();

    // Leave A=0x01, B=0x03 from 7 x 37. Then run with S=2 without clra_ldb.
    load8(8'h07);
    run8(8'h25, done_at);
    check("res_7x37", {if8.aval, if8.bval}, 16'h0103);
    release8();
    run8(8'h02, done_at);
`ifdef MULT_AUTOCLEAR_EN
    check("res_acc", {if8.aval, if8.bval}, 16'h0006);
`else
    check("res_acc", {if8.aval, if8.bval}, 16'h0007);
`endif
    release8();

    // Reset in the middle of ADD.
    load8(8'h55);
    @(negedge clk);
    if8.s   = 8'h33;
    if8.run = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_prod8", {if8.aval, if8.bval}, 16'h0000);
    check("abort_x8", if8.x, 1'b0);
    check("abort_busy8", if8.busy, 1'b0);
    if8.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Random operations. They cover chained runs, run dropped mid-operation,
    // and clra_ldb asserted together with run.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0)
        load8(($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom));
      sv = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
      @(negedge clk);
      if8.s        = sv;
      if8.run      = 1'b1;
      if8.clra_ldb = 1'($urandom_range(0, 1));
      @(negedge clk);
      if8.clra_ldb = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 10)) @(negedge clk);
        if8.run = 1'b0;
      end
      for (int k = 0; k < 40 && if8.busy; k++) @(negedge clk);
      check("rand_wait8", if8.busy, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release8();
    end

    // WIDTH=16: -1 x 2.
    @(negedge clk);
    if16.clra_ldb = 1'b1;
    if16.s        = 16'hFFFF;
    @(negedge clk);
    if16.clra_ldb = 1'b0;
    if16.s        = 16'h0002;
    if16.run      = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if16.busy) busy_cnt++;
      else break;
    end
    check("busy_len16", busy_cnt, 32);
    check("res16", {if16.aval, if16.bval, if16.x}, {32'hFFFFFFFE, 1'b1});
    @(negedge clk);
    if16.run = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
